// File: rtl/tiger_cache_pkg.sv
// Shared definitions for the Tiger data-cache port: command-word layout and arbiter state.
package tiger_cache_pkg;

    localparam int unsigned CACHE_CMD_W   = 128;
    localparam int unsigned PROC_FLAG_BIT = 103;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } arb_state_e;

    // Cache command word; proc sits at bit 103 and marks processor-originated traffic.
    typedef struct packed {
        logic [23:0] rsvd_hi;
        logic        proc;
        logic [2:0]  rsvd_lo;
        logic        flush;
        logic        mem64;
        logic        mem16;
        logic        mem8;
        logic [63:0] data;
        logic [31:0] addr;
    } cache_cmd_t;

endpackage

// File: rtl/cache_rr_picker.sv
// Round-robin pick: first pending requester after last_id, wrapping modulo NUM_REQ.
module cache_rr_picker #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned GRANT_W = 2
) (
    input  logic [NUM_REQ-1:0] pending,
    input  logic [GRANT_W-1:0] last_id,
    output logic               any,
    output logic [GRANT_W-1:0] winner
);

    logic [NUM_REQ-1:0] rotated;
    logic [GRANT_W-1:0] offset;
    logic [GRANT_W:0]   sum;

    always_comb begin
        // Bit j of rotated is requester (last_id + 1 + j) mod NUM_REQ.
        rotated = NUM_REQ'({pending, pending} >> (32'(last_id) + 32'd1));
        offset  = '0;
        for (int j = NUM_REQ - 1; j >= 0; j--) begin
            if (rotated[j]) begin
                offset = GRANT_W'(j);
            end
        end
        sum    = (GRANT_W+1)'(last_id) + (GRANT_W+1)'(offset) + (GRANT_W+1)'(1);
        winner = (sum >= (GRANT_W+1)'(NUM_REQ)) ? GRANT_W'(sum - (GRANT_W+1)'(NUM_REQ))
                                                 : GRANT_W'(sum);
        any    = |pending;
    end

endmodule

// File: rtl/cache_port_arbiter.sv
// Shares the data-cache port between the processor (requester 0) and accelerators,
// round-robin with a bounded number of accepts per grant.
module cache_port_arbiter
    import tiger_cache_pkg::*;
#(
    parameter int unsigned NUM_REQ  = 4,
    parameter int unsigned GRANT_W  = 2,
    parameter int unsigned MAX_HOLD = 4
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic [NUM_REQ-1:0]             req_read,
    input  logic [NUM_REQ-1:0]             req_write,
    input  logic [NUM_REQ*CACHE_CMD_W-1:0] req_writedata,
    output logic [NUM_REQ-1:0]             req_waitrequest,
    output logic [CACHE_CMD_W-1:0]         req_readdata,
    output logic                           avm_CACHE_read,
    output logic                           avm_CACHE_write,
    output logic [CACHE_CMD_W-1:0]         avm_CACHE_writedata,
    input  logic [CACHE_CMD_W-1:0]         avm_CACHE_readdata,
    input  logic                           avm_CACHE_waitrequest,
    output logic                           grant_valid,
    output logic [GRANT_W-1:0]             grant_id
);

    localparam int unsigned CNT_W = 4;

    arb_state_e          state_q, state_d;
    logic [GRANT_W-1:0]  grant_d;
    logic [GRANT_W-1:0]  last_id_q, last_id_d;
    logic [CNT_W-1:0]    hold_cnt_q, hold_cnt_d;
    cache_cmd_t          cmd_words [NUM_REQ];
    cache_cmd_t          cmd_sel;
    logic                sel_read, sel_write, accept;
    logic                pick_any;
    logic [GRANT_W-1:0]  pick_winner;

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_slice
        assign cmd_words[i] = cache_cmd_t'(req_writedata[i*CACHE_CMD_W +: CACHE_CMD_W]);
    end

    assign sel_read     = req_read[grant_id];
    assign sel_write    = req_write[grant_id];
    assign accept       = (state_q == ST_BUSY) && (sel_read || sel_write) && !avm_CACHE_waitrequest;
    assign req_readdata = avm_CACHE_readdata;

    cache_rr_picker #(
        .NUM_REQ (NUM_REQ),
        .GRANT_W (GRANT_W)
    ) u_picker (
        .pending (req_read | req_write),
        .last_id (last_id_q),
        .any     (pick_any),
        .winner  (pick_winner)
    );

    // Last_id resets to the top index so requester 0 is scanned first.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            grant_id   <= '0;
            last_id_q  <= GRANT_W'(NUM_REQ - 1);
            hold_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            grant_id   <= grant_d;
            last_id_q  <= last_id_d;
            hold_cnt_q <= hold_cnt_d;
        end
    end

    // Grant on any pending request; leave on release or after MAX_HOLD accepts.
    always_comb begin
        state_d    = state_q;
        grant_d    = grant_id;
        last_id_d  = last_id_q;
        hold_cnt_d = hold_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (pick_any) begin
                    state_d    = ST_BUSY;
                    grant_d    = pick_winner;
                    hold_cnt_d = '0;
                end
            end
            ST_BUSY: begin
                if (!sel_read && !sel_write) begin
                    state_d   = ST_IDLE;
                    last_id_d = grant_id;
                end else if (accept) begin
                    hold_cnt_d = hold_cnt_q + CNT_W'(1);
                    if (hold_cnt_d == CNT_W'(MAX_HOLD)) begin
                        state_d   = ST_IDLE;
                        last_id_d = grant_id;
                    end
                end
            end
        endcase
    end

    // Forward the granted requester; the identity flag always reflects the grant.
    always_comb begin
        avm_CACHE_read      = 1'b0;
        avm_CACHE_write     = 1'b0;
        avm_CACHE_writedata = '0;
        req_waitrequest     = '1;
        grant_valid         = (state_q == ST_BUSY);
        cmd_sel             = cmd_words[grant_id];
        cmd_sel.proc        = (grant_id == '0);
        if (state_q == ST_BUSY) begin
            avm_CACHE_read            = sel_read;
            avm_CACHE_write           = sel_write;
            avm_CACHE_writedata       = cmd_sel;
            req_waitrequest[grant_id] = avm_CACHE_waitrequest;
        end
    end

endmodule

// File: tb/tb_cache_port_arbiter.sv
// Directed bench for cache_port_arbiter with a cycle-level reference model of the arbitration rules.
module tb_cache_port_arbiter;
    import tiger_cache_pkg::*;

    localparam int unsigned NUM_REQ  = 4;
    localparam int unsigned GRANT_W  = 2;
    localparam int unsigned MAX_HOLD = 4;
    localparam int unsigned W        = CACHE_CMD_W;

    logic                   clk = 1'b0;
    logic                   reset_n;
    logic [NUM_REQ-1:0]     req_read, req_write;
    logic [NUM_REQ*W-1:0]   req_writedata;
    logic [NUM_REQ-1:0]     req_waitrequest;
    logic [W-1:0]           req_readdata;
    logic                   avm_CACHE_read, avm_CACHE_write;
    logic [W-1:0]           avm_CACHE_writedata;
    logic [W-1:0]           avm_CACHE_readdata;
    logic                   avm_CACHE_waitrequest;
    logic                   grant_valid;
    logic [GRANT_W-1:0]     grant_id;
    logic [W-1:0]           cmd [NUM_REQ];

    always #5 clk = ~clk;

    always_comb req_writedata = {cmd[3], cmd[2], cmd[1], cmd[0]};

    cache_port_arbiter #(
        .NUM_REQ  (NUM_REQ),
        .GRANT_W  (GRANT_W),
        .MAX_HOLD (MAX_HOLD)
    ) dut (
        .clk                   (clk),
        .reset_n               (reset_n),
        .req_read              (req_read),
        .req_write             (req_write),
        .req_writedata         (req_writedata),
        .req_waitrequest       (req_waitrequest),
        .req_readdata          (req_readdata),
        .avm_CACHE_read        (avm_CACHE_read),
        .avm_CACHE_write       (avm_CACHE_write),
        .avm_CACHE_writedata   (avm_CACHE_writedata),
        .avm_CACHE_readdata    (avm_CACHE_readdata),
        .avm_CACHE_waitrequest (avm_CACHE_waitrequest),
        .grant_valid           (grant_valid),
        .grant_id              (grant_id)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [127:0] pack(input int q[$]);
        logic [127:0] v = '0;
        foreach (q[i]) v = (v << 4) | 128'(q[i]);
        return v;
    endfunction

    // Reference model: who owns the port, who owned it last, accepts in this grant.
    bit                 cmp_en = 1'b0;
    bit                 m_busy = 1'b0;
    logic [GRANT_W-1:0] m_gid  = '0;
    logic [GRANT_W-1:0] m_last = GRANT_W'(NUM_REQ - 1);
    int                 m_cnt  = 0;
    int                 grant_log[$];
    int                 acc_log[$];

    always @(negedge clk) begin
        logic               e_rd, e_wr;
        logic [W-1:0]       e_wd;
        logic [NUM_REQ-1:0] e_wait;
        logic [GRANT_W-1:0] idx;
        bit                 found;
        e_rd   = 1'b0;
        e_wr   = 1'b0;
        e_wd   = '0;
        e_wait = '1;
        if (m_busy) begin
            e_rd                = req_read[m_gid];
            e_wr                = req_write[m_gid];
            e_wd                = cmd[m_gid];
            e_wd[PROC_FLAG_BIT] = (m_gid == '0);
            e_wait[m_gid]       = avm_CACHE_waitrequest;
        end
        if (cmp_en) begin
            check("grant_valid", 128'(grant_valid), 128'(m_busy));
            check("grant_id", 128'(grant_id), 128'(m_gid));
            check("avm_read", 128'(avm_CACHE_read), 128'(e_rd));
            check("avm_write", 128'(avm_CACHE_write), 128'(e_wr));
            check("avm_writedata", avm_CACHE_writedata, e_wd);
            check("req_waitrequest", 128'(req_waitrequest), 128'(e_wait));
            check("req_readdata", req_readdata, avm_CACHE_readdata);
            if (m_busy) check("legal_stimulus", 128'(e_rd & e_wr), 128'(0));
        end
        if (!reset_n) begin
            m_busy = 1'b0;
            m_gid  = '0;
            m_last = GRANT_W'(NUM_REQ - 1);
            m_cnt  = 0;
        end else if (!m_busy) begin
            found = 1'b0;
            for (int k = 1; k <= NUM_REQ; k++) begin
                idx = GRANT_W'((int'(m_last) + k) % NUM_REQ);
                if (!found && (req_read[idx] || req_write[idx])) begin
                    found  = 1'b1;
                    m_busy = 1'b1;
                    m_gid  = idx;
                    m_cnt  = 0;
                    grant_log.push_back(int'(idx));
                end
            end
        end else if (!e_rd && !e_wr) begin
            m_busy = 1'b0;
            m_last = m_gid;
            acc_log.push_back(m_cnt);
        end else if (!avm_CACHE_waitrequest) begin
            m_cnt++;
            if (m_cnt == MAX_HOLD) begin
                m_busy = 1'b0;
                m_last = m_gid;
                acc_log.push_back(m_cnt);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic clear_logs();
        grant_log.delete();
        acc_log.delete();
    endtask

    initial begin
        bit found;
        reset_n               = 1'b0;
        req_read              = '0;
        req_write             = '0;
        avm_CACHE_waitrequest = 1'b0;
        avm_CACHE_readdata    = '0;
        for (int i = 0; i < NUM_REQ; i++) cmd[i] = '0;
        tick();
        tick();
        cmp_en = 1'b1;
        smp();
        check("rst_grant_valid", 128'(grant_valid), 128'(0));
        check("rst_grant_id", 128'(grant_id), 128'(0));
        check("rst_waitrequest", 128'(req_waitrequest), 128'h0f);
        check("rst_avm_rw", 128'({avm_CACHE_read, avm_CACHE_write}), 128'(0));
        check("rst_writedata", avm_CACHE_writedata, 128'(0));

        // Single processor read.
        tick();
        clear_logs();
        reset_n            = 1'b1;
        avm_CACHE_readdata = 128'h0123_4567_89ab_cdef_0000_1111_dead_beef;
        cmd[0]             = 128'h0000_0000_0000_0000_0000_0000_0000_0100;
        req_read[0]        = 1'b1;
        smp();
        check("s1_arb_cycle_gv", 128'(grant_valid), 128'(0));
        check("s1_arb_cycle_wait", 128'(req_waitrequest), 128'h0f);
        tick();
        smp();
        check("s1_gv", 128'(grant_valid), 128'(1));
        check("s1_wait", 128'(req_waitrequest), 128'h0e);
        check("s1_readdata", req_readdata, 128'h0123_4567_89ab_cdef_0000_1111_dead_beef);
        check("s1_avm_read", 128'(avm_CACHE_read), 128'(1));
        check("s1_proc_flag", 128'(avm_CACHE_writedata[PROC_FLAG_BIT]), 128'(1));
        tick();
        req_read[0] = 1'b0;
        tick();
        tick();
        check("s1_grants", pack(grant_log), 128'h0);
        check("s1_accepts", pack(acc_log), 128'h1);

        // Three accelerators streaming writes with their flag bit set.
        clear_logs();
        cmd[1]    = 128'h0000_0080_1111_1111_1111_1111_0000_1000;
        cmd[2]    = 128'h0000_0080_2222_2222_2222_2222_0000_2000;
        cmd[3]    = 128'h0000_0080_3333_3333_3333_3333_0000_3000;
        req_write = 4'b1110;
        repeat (20) tick();
        req_write = '0;
        tick();
        tick();
        check("s2_grant_order", pack(grant_log), 128'h1231);
        check("s2_accepts", pack(acc_log), 128'h4444);

        // Processor waits behind a streaming accelerator.
        clear_logs();
        cmd[0]       = 128'h0000_0000_0000_0000_0000_0000_0000_0200;
        req_write[2] = 1'b1;
        tick();
        req_read[0]  = 1'b1;
        found        = 1'b0;
        for (int i = 0; i < MAX_HOLD + 2; i++) begin
            smp();
            if (grant_valid && grant_id == 0) begin
                found = 1'b1;
                break;
            end
            tick();
        end
        check("s3_proc_granted", 128'(found), 128'(1));
        check("s3_proc_flag", 128'(avm_CACHE_writedata[PROC_FLAG_BIT]), 128'(1));
        check("s3_proc_read", 128'({avm_CACHE_read, avm_CACHE_write}), 128'b10);
        tick();
        req_read[0]  = 1'b0;
        req_write[2] = 1'b0;
        tick();
        tick();
        check("s3_grants", pack(grant_log), 128'h20);
        check("s3_accepts", pack(acc_log), 128'h41);

        // Cache stall during a write.
        clear_logs();
        cmd[1]                = 128'h0000_0000_aaaa_bbbb_cccc_dddd_0000_1800;
        req_write[1]          = 1'b1;
        avm_CACHE_waitrequest = 1'b1;
        tick();
        for (int i = 0; i < 5; i++) begin
            smp();
            check("s4_stall_wait", 128'(req_waitrequest[1]), 128'(1));
            tick();
        end
        avm_CACHE_waitrequest = 1'b0;
        smp();
        check("s4_accept_wait", 128'(req_waitrequest), 128'h0d);
        tick();
        req_write[1] = 1'b0;
        tick();
        tick();
        check("s4_grants", pack(grant_log), 128'h1);
        check("s4_accepts", pack(acc_log), 128'h1);

        // Early release by requester 3, then the scan restarts at 0.
        clear_logs();
        cmd[3]       = 128'h0000_0000_4444_5555_6666_7777_0000_3800;
        req_write[3] = 1'b1;
        tick();
        tick();
        tick();
        req_write[3] = 1'b0;
        tick();
        req_read[0]  = 1'b1;
        req_write[2] = 1'b1;
        tick();
        smp();
        check("s5_next_winner", 128'(grant_id), 128'(0));
        check("s5_next_gv", 128'(grant_valid), 128'(1));
        tick();
        req_read[0] = 1'b0;
        tick();
        tick();
        tick();
        req_write[2] = 1'b0;
        tick();
        tick();
        check("s5_grants", pack(grant_log), 128'h302);
        check("s5_accepts", pack(acc_log), 128'h211);

        // Reset during a stalled write.
        clear_logs();
        req_write[2]          = 1'b1;
        avm_CACHE_waitrequest = 1'b1;
        tick();
        reset_n = 1'b0;
        tick();
        smp();
        check("s6_rst_rw", 128'({avm_CACHE_read, avm_CACHE_write}), 128'(0));
        check("s6_rst_wait", 128'(req_waitrequest), 128'h0f);
        check("s6_rst_gv", 128'(grant_valid), 128'(0));
        tick();
        req_read[0]           = 1'b1;
        reset_n               = 1'b1;
        avm_CACHE_waitrequest = 1'b0;
        tick();
        smp();
        check("s6_first_grant", 128'(grant_id), 128'(0));
        check("s6_first_gv", 128'(grant_valid), 128'(1));
        tick();
        req_read[0] = 1'b0;
        tick();
        tick();
        tick();
        req_write[2] = 1'b0;
        tick();
        tick();
        check("s6_grants", pack(grant_log), 128'h202);
        check("s6_accepts", pack(acc_log), 128'h11);

        repeat (3) tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cache_port_arbiter.md
Name: cache_port_arbiter

Overview:
- Shares the single 128-bit data-cache port (avm_CACHE_* command word) between the Tiger processor (requester 0) and up to NUM_REQ-1 hardware accelerators.
- Round-robin grant with a bounded hold, so one accelerator streaming transfers cannot starve the processor.
- Sits between the requesters' cache masters and the data cache slave.
- Forces the processor-identity flag, bit 103 of the command word, to match the granted requester.

Parameters:
- NUM_REQ, 4: number of requesters. Index 0 is always the processor. Legal range 2..8.
- GRANT_W, 2: width of the grant index. Must satisfy GRANT_W = ceil(log2(NUM_REQ)).
- MAX_HOLD, 4: maximum accepted transfers per grant before forced rotation. Legal range 1..15.

Ports:
- clk  in  1  clock; all logic is on the rising edge.
- reset_n  in  1  synchronous, active-low reset.
- req_read  in  NUM_REQ  read request, one bit per requester.
- req_write  in  NUM_REQ  write request, one bit per requester.
- req_writedata  in  NUM_REQ*128  command words; requester i occupies bits [128*i+127 : 128*i].
- req_waitrequest  out  NUM_REQ  per-requester stall.
- req_readdata  out  128  cache readdata, broadcast to all requesters.
- avm_CACHE_read  out  1  forwarded read.
- avm_CACHE_write  out  1  forwarded write.
- avm_CACHE_writedata  out  128  forwarded command word.
- avm_CACHE_readdata  in  128  cache read data, valid in the accept cycle.
- avm_CACHE_waitrequest  in  1  cache stall.
- grant_valid  out  1  a grant is active (BUSY state).
- grant_id  out  GRANT_W  index of the granted requester.

Behaviour:
- Transfer protocol: Avalon-MM with waitrequest, zero read latency.
  - A transfer is accepted in a cycle where the forwarded read or write is high and avm_CACHE_waitrequest is low.
  - Read data for the granted requester is valid in that same cycle.
- Registered state: state (IDLE or BUSY), grant_id, last_id, hold_cnt (4 bits).
- Reset (reset_n=0 at a rising edge):
  - state=IDLE, grant_valid=0, grant_id=0, last_id=NUM_REQ-1 (so requester 0 wins first), hold_cnt=0.
  - Combinational outputs while in reset-state IDLE: cache read/write=0, writedata=0, req_waitrequest all 1.
  - Reset mid-transfer abandons the transfer; no cache command is issued in the following IDLE cycle.
- IDLE:
  - Nothing is forwarded; req_waitrequest = all 1s.
  - pending = req_read | req_write.
  - If pending is nonzero: winner = first set bit scanning last_id+1, last_id+2, … modulo NUM_REQ. Next edge: state=BUSY, grant_id=winner, hold_cnt=0.
  - Arbitration costs exactly 1 cycle; the earliest accept is in the cycle after the request is first seen.
- BUSY, with g = grant_id:
  - avm_CACHE_read = req_read[g]; avm_CACHE_write = req_write[g].
  - avm_CACHE_writedata = req_writedata slice g, except bit 103 forced to (g==0).
  - req_waitrequest[g] = avm_CACHE_waitrequest; every other bit is 1.
  - req_read[g] and req_write[g] both high: forwarded unchanged (illegal stimulus; the bench flags it).
  - req_read[g]=0 and req_write[g]=0 (grant released): next edge state=IDLE, last_id=g.
  - On accept: hold_cnt+1. If hold_cnt+1 == MAX_HOLD, next edge state=IDLE, last_id=g. Otherwise stay BUSY.
  - Rotation happens even if no other requester is pending; the same requester may then win again after the IDLE cycle.
- req_readdata = avm_CACHE_readdata in all states. It is meaningful only to the requester whose waitrequest is low in an accept cycle.
- grant_valid = (state==BUSY). grant_id holds its last value while IDLE.
- Requests that change while their waitrequest is high are not defined; requesters must hold their signals stable.

Decomposition:
- Shared package tiger_cache_pkg:
  - CACHE_CMD_W = 128.
  - PROC_FLAG_BIT = 103.
  - Command-word field offsets: address [31:0], data [95:32], mem8 96, mem16 97, mem64 98, flush 99.
  - State encoding IDLE=0, BUSY=1.
- Sub-module cache_rr_picker: purely combinational rotate-and-priority-encode.
  - Inputs: pending[NUM_REQ], last_id.
  - Outputs: any, winner.
  - The FSM, mux and hold counter stay in cache_port_arbiter.

Test Plan:
- Reset then single requester: processor (req 0) asserts a read with the cache not waiting → grant_valid=1 one cycle later; accept in that cycle; req_readdata equals the cache value (e.g. 0x…DEADBEEF); req_waitrequest[0]=0 only in the accept cycle.
- Contention, NUM_REQ=4: reqs 1, 2 and 3 write continuously with MAX_HOLD=4 → each gets exactly 4 accepts; grant order 1,2,3,1; one IDLE cycle between grants; forwarded bit 103=0 throughout.
- Processor fairness: req 0 read pending while req 2 streams → req 0 is granted within at most MAX_HOLD+1 cycles after req 2's grant ends; forwarded bit 103=1 even when the processor drives it 0.
- Cache stall: avm_CACHE_waitrequest held high 5 cycles during req 1 write → req_waitrequest[1]=1 for those 5 cycles; hold_cnt unchanged; a single accept in cycle 6.
- Early release: req 3 drops its request after 2 accepts → IDLE next edge, last_id=3; next winner scan starts at index 0.
- Reset mid-transfer: reset_n=0 during a stalled req 2 write → next cycle cache read/write=0, req_waitrequest=4'b1111, grant_valid=0; after release the first grant goes to req 0 when reqs 0 and 2 both pend.
